// File: rtl/clk_div_prog.sv
// Programmable clock divider: one-cycle tick every P clk cycles plus a 2*P square wave.
// A new divisor takes effect only at a wrap or clr edge, so no period is ever cut short.
module clk_div_prog #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             tick,
  output logic             slow_clk,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_pending,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             slow_q, slow_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;

  logic load_ok, wrap, apply;

  always_comb begin
    load_ok   = div_load && (div_val != '0);
    wrap      = en && !clr && (cnt_q == p_q - ONE);
    apply     = wrap || clr;

    cnt_d     = cnt_q;
    p_d       = p_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    slow_d    = slow_q;
    pending_d = pending_q;
    err_d     = div_load && (div_val == '0);

    // clr wins over a coincident wrap: restart phase, no tick
    if (clr) begin
      cnt_d  = '0;
      slow_d = 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        slow_d = ~slow_q;
      end else begin
        cnt_d  = cnt_q + ONE;
      end
    end

    // Divisor changes only on a period boundary; a same-edge load bypasses pend
    if (apply) begin
      if (load_ok) begin
        p_d       = div_val;
        pending_d = 1'b0;
      end else if (pending_q) begin
        p_d       = pend_q;
        pending_d = 1'b0;
      end
    end else if (load_ok) begin
      pend_d    = div_val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      p_q       <= DEF_P;
      pend_q    <= '0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign cnt         = cnt_q;
  assign div_cur     = p_q;
  assign tick        = tick_q;
  assign slow_clk    = slow_q;
  assign div_pending = pending_q;
  assign div_err     = err_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 26, giving the counter and divisor width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 50000000, giving the tick period in clk cycles after reset (range 1..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, the count enable; when low, the counter holds.
REQ-006 SHALL have port clr, input, 1, a synchronous restart of the count phase that keeps the current divisor.
REQ-007 SHALL have port div_load, input, 1, a one-cycle strobe that requests a new divisor.
REQ-008 SHALL have port div_val, input, WIDTH, the requested period in clk cycles, sampled when div_load=1.
REQ-009 SHALL have port tick, output, 1, a one-clk-cycle pulse once per period.
REQ-010 SHALL have port slow_clk, output, 1, a 50% duty square wave with period 2*P.
REQ-011 SHALL have port cnt, output, WIDTH, the current phase count (0..P-1).
REQ-012 SHALL have port div_cur, output, WIDTH, the active period P.
REQ-013 SHALL have port div_pending, output, 1, high while a loaded divisor awaits application.
REQ-014 SHALL have port div_err, output, 1, a one-cycle pulse when div_load is asserted with div_val=0.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-016 Wrap condition: en=1, clr=0, cnt==P-1.
REQ-017 On a cycle with en=1, clr=0 and no wrap: cnt<=cnt+1 and tick<=0.
REQ-018 On a wrap: cnt<=0, tick<=1 and slow_clk<=~slow_clk in the same edge.
REQ-019 With en=0 and clr=0: cnt and slow_clk SHALL hold, tick<=0, and load handling SHALL continue.
REQ-020 With clr=1: cnt<=0, tick<=0 and slow_clk<=0 regardless of en; clr SHALL override a wrap in the same cycle, producing no tick.
REQ-021 At P=1: a wrap occurs every enabled cycle, tick stays high continuously, and slow_clk toggles every cycle.
REQ-022 Accepted load (div_load=1, div_val!=0): pend<=div_val and div_pending<=1; a later load before application SHALL overwrite pend (last wins).
REQ-023 Rejected load (div_load=1, div_val=0): div_err<=1 for one cycle, with pend, div_pending and P unchanged.
REQ-024 Application: at the next wrap or clr edge with div_pending=1, P<=pend and div_pending<=0; P never changes mid-period, so no runt tick or runt half-cycle occurs.
REQ-025 Load coinciding with wrap or clr: div_val SHALL be applied directly at that edge, bypassing pend, with div_pending<=0.
REQ-026 Counter arithmetic SHALL be WIDTH bits unsigned; cnt SHALL never exceed P-1, and no overflow path exists.
REQ-027 div_cur SHALL equal P at all times.

Reset
REQ-028 While rst=1 at a clk edge: cnt<=0, tick<=0, slow_clk<=0, P<=DEFAULT_DIV, pend<=0, div_pending<=0, div_err<=0.
REQ-029 rst SHALL have priority over clr, en and div_load.
REQ-030 Reset mid-period SHALL discard any pending divisor.
REQ-031 The first tick after rst deasserts with en=1 SHALL occur exactly DEFAULT_DIV cycles later.

Verification (WIDTH=4, DEFAULT_DIV=3)
REQ-032 Release rst, hold en=1 -> cnt follows 0,1,2,0,...; tick high on every 3rd edge; slow_clk period 6 cycles.
REQ-033 Load div_val=5 while cnt=1 -> div_pending=1; the current period still ends at cnt=2; the next period is 5 cycles; div_pending clears at that wrap.
REQ-034 Load div_val=0 -> div_err pulses one cycle; P stays 3; tick cadence is unchanged.
REQ-035 Drop en for 4 cycles at cnt=1, then restore -> cnt holds at 1 with no tick; the next tick comes 2 enabled cycles after restore.
REQ-036 Assert clr and div_load (div_val=1) on a wrap cycle -> no tick, cnt=0, slow_clk=0, P=1; tick is then high every cycle.
REQ-037 Assert rst with div_pending=1 -> P=3, div_pending=0, and all outputs return to their reset values on the next edge.
